// File: rtl/i2c_regmap.sv
// rtl/i2c_regmap.sv - register map behind the I2C slave
//
// Purpose: decodes single-shot write strobes from the I2C slave into ID/version,
// control, self-clearing command, sticky W1C status with IRQ, a saturating error
// counter and shadowed GP registers that commit together when the transaction ends.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   i2c_active    high between START and STOP; its falling edge commits GP shadows
//   addr, wdata   register address / write data from the slave
//   wr_en_wdata   write-valid level; only its rising edge performs a write
//   rdata         registered read data for addr (1 clk latency)
//   hw_event      one-clk event strobes that set STATUS bits
//   ctrl          CTRL register
//   cmd_pulse     one-clk pulse per CMD bit written as 1
//   irq           level interrupt, |(STATUS & IRQ_EN) registered
//   gp_out        committed GP registers, GP[0] in bits [7:0]

module i2c_regmap #(
  parameter logic [7:0] CHIP_ID = 8'hA5,
  parameter logic [7:0] VERSION = 8'h01,
  parameter int         NUM_GP  = 4,
  parameter logic [7:0] GP_BASE = 8'h10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i2c_active,
  input  logic [7:0]          addr,
  input  logic [7:0]          wdata,
  input  logic                wr_en_wdata,
  output logic [7:0]          rdata,
  input  logic [7:0]          hw_event,
  output logic [7:0]          ctrl,
  output logic [7:0]          cmd_pulse,
  output logic                irq,
  output logic [NUM_GP*8-1:0] gp_out
);

  logic                wr_en_q,     wr_en_d;
  logic                active_q,    active_d;
  logic [7:0]          ctrl_q,      ctrl_d;
  logic [7:0]          cmd_pulse_q, cmd_pulse_d;
  logic [7:0]          status_q,    status_d;
  logic [7:0]          irq_en_q,    irq_en_d;
  logic [7:0]          scratch_q,   scratch_d;
  logic [7:0]          err_cnt_q,   err_cnt_d;
  logic                irq_q,       irq_d;
  logic [7:0]          rdata_q,     rdata_d;
  logic [NUM_GP*8-1:0] shadow_q,    shadow_d;
  logic [NUM_GP*8-1:0] gp_out_q,    gp_out_d;

  logic       strobe;
  logic       commit;
  logic       gp_hit;
  logic [7:0] gp_rd;
  logic [7:0] clr;

  always_comb begin
    strobe = wr_en_wdata & ~wr_en_q;
    commit = active_q & ~i2c_active;
    wr_en_d  = wr_en_wdata;
    active_d = i2c_active;

    gp_hit = 1'b0;
    gp_rd  = 8'h00;
    for (int n = 0; n < NUM_GP; n++) begin
      if (addr == GP_BASE + 8'(n)) begin
        gp_hit = 1'b1;
        gp_rd  = shadow_q[n*8 +: 8];
      end
    end

    ctrl_d      = ctrl_q;
    cmd_pulse_d = 8'h00;
    irq_en_d    = irq_en_q;
    scratch_d   = scratch_q;
    err_cnt_d   = err_cnt_q;
    shadow_d    = shadow_q;
    clr         = 8'h00;

    if (strobe) begin
      case (addr)
        8'h02: ctrl_d      = wdata;
        8'h03: cmd_pulse_d = wdata;
        8'h04: clr         = wdata;
        8'h05: irq_en_d    = wdata;
        8'h06: scratch_d   = wdata;
        8'h07: err_cnt_d   = 8'h00;
        default: begin
          // ID, VERSION and anything not decoded land here as errors.
          if (gp_hit) begin
            for (int n = 0; n < NUM_GP; n++) begin
              if (addr == GP_BASE + 8'(n)) shadow_d[n*8 +: 8] = wdata;
            end
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      endcase
    end

    // Set wins over clear when an event arrives on the clearing clk.
    status_d = (status_q & ~clr) | hw_event;

    // Commit takes shadow_d so a same-clk strobe is included.
    gp_out_d = commit ? shadow_d : gp_out_q;

    irq_d = |(status_q & irq_en_q);

    case (addr)
      8'h00:   rdata_d = CHIP_ID;
      8'h01:   rdata_d = VERSION;
      8'h02:   rdata_d = ctrl_q;
      8'h04:   rdata_d = status_q;
      8'h05:   rdata_d = irq_en_q;
      8'h06:   rdata_d = scratch_q;
      8'h07:   rdata_d = err_cnt_q;
      default: rdata_d = gp_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      active_q    <= 1'b0;
      ctrl_q      <= 8'h00;
      cmd_pulse_q <= 8'h00;
      status_q    <= 8'h00;
      irq_en_q    <= 8'h00;
      scratch_q   <= 8'h00;
      err_cnt_q   <= 8'h00;
      irq_q       <= 1'b0;
      rdata_q     <= 8'h00;
      shadow_q    <= '0;
      gp_out_q    <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      active_q    <= active_d;
      ctrl_q      <= ctrl_d;
      cmd_pulse_q <= cmd_pulse_d;
      status_q    <= status_d;
      irq_en_q    <= irq_en_d;
      scratch_q   <= scratch_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      shadow_q    <= shadow_d;
      gp_out_q    <= gp_out_d;
    end
  end

  assign rdata     = rdata_q;
  assign ctrl      = ctrl_q;
  assign cmd_pulse = cmd_pulse_q;
  assign irq       = irq_q;
  assign gp_out    = gp_out_q;

endmodule

// File: tb/tb_i2c_regmap.sv
// tb/tb_i2c_regmap.sv - self-checking bench for i2c_regmap

module tb_i2c_regmap;

  localparam logic [7:0] GPB = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_active = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        wr_en_wdata = 1'b0;
  logic [7:0]  rdata;
  logic [7:0]  hw_event = 8'h00;
  logic [7:0]  ctrl;
  logic [7:0]  cmd_pulse;
  logic        irq;
  logic [31:0] gp_out;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_regmap #(.CHIP_ID(8'hA5), .VERSION(8'h01), .NUM_GP(4), .GP_BASE(GPB)) dut (
    .clk(clk), .rst_n(rst_n), .i2c_active(i2c_active), .addr(addr), .wdata(wdata),
    .wr_en_wdata(wr_en_wdata), .rdata(rdata), .hw_event(hw_event), .ctrl(ctrl),
    .cmd_pulse(cmd_pulse), .irq(irq), .gp_out(gp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_wr;
    logic [7:0] a;
    logic [7:0] d;     // write data, or expected rdata for a read
    int         hold;  // clks wr_en_wdata stays high
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    addr = a;
    wdata = d;
    wr_en_wdata = 1'b1;
    repeat (hold) @(negedge clk);
    wr_en_wdata = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    addr = a;
    @(negedge clk);
    chk(name, {24'h0, rdata}, {24'h0, exp});
  endtask

  vec_t vecs[16];
  int   pulses;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 8'hA5, 0,   "read_id"};
    vecs[1]  = '{1'b0, 8'h01, 8'h01, 0,   "read_version"};
    vecs[2]  = '{1'b1, 8'h02, 8'h3C, 200, "wr_ctrl_held"};
    vecs[3]  = '{1'b0, 8'h02, 8'h3C, 0,   "read_ctrl"};
    vecs[4]  = '{1'b0, 8'h07, 8'h00, 0,   "errcnt_after_hold"};
    vecs[5]  = '{1'b1, 8'h05, 8'h04, 3,   "wr_irq_en"};
    vecs[6]  = '{1'b0, 8'h05, 8'h04, 0,   "read_irq_en"};
    vecs[7]  = '{1'b1, 8'h06, 8'h5A, 1,   "wr_scratch"};
    vecs[8]  = '{1'b0, 8'h06, 8'h5A, 0,   "read_scratch"};
    vecs[9]  = '{1'b0, 8'h03, 8'h00, 0,   "read_cmd"};
    vecs[10] = '{1'b0, 8'h20, 8'h00, 0,   "read_unmapped"};
    vecs[11] = '{1'b1, 8'h00, 8'hFF, 5,   "wr_id_err"};
    vecs[12] = '{1'b0, 8'h07, 8'h01, 0,   "errcnt_one"};
    vecs[13] = '{1'b1, 8'h07, 8'h00, 1,   "wr_errcnt_clr"};
    vecs[14] = '{1'b0, 8'h07, 8'h00, 0,   "errcnt_cleared"};
    vecs[15] = '{1'b0, 8'h00, 8'hA5, 0,   "read_id_again"};

    repeat (3) @(negedge clk);
    chk("reset_rdata", {24'h0, rdata}, 32'h0);
    chk("reset_ctrl", {24'h0, ctrl}, 32'h0);
    chk("reset_cmd", {24'h0, cmd_pulse}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_gp", gp_out, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d, vecs[i].hold);
      else               do_read(vecs[i].a, vecs[i].d, vecs[i].name);
    end
    chk("ctrl_out", {24'h0, ctrl}, 32'h3C);
    chk("irq_idle", {31'h0, irq}, 32'h0);

    // CMD: level held 20 clks must yield exactly one pulse, on the clk after the strobe
    @(negedge clk);
    addr = 8'h03; wdata = 8'h81; wr_en_wdata = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("cmd_pulse_val", {24'h0, cmd_pulse}, 32'h81);
      if (i == 1) chk("cmd_pulse_gone", {24'h0, cmd_pulse}, 32'h0);
      if (cmd_pulse != 8'h00) pulses++;
    end
    wr_en_wdata = 1'b0;
    chk("cmd_pulse_count", pulses, 1);

    // STATUS/irq: set, then clear racing a new event, then real clear
    @(negedge clk); hw_event = 8'h04;
    @(negedge clk); hw_event = 8'h00;
    @(negedge clk);
    chk("irq_set", {31'h0, irq}, 32'h1);
    @(negedge clk);
    addr = 8'h04; wdata = 8'h04; wr_en_wdata = 1'b1; hw_event = 8'h04;
    @(negedge clk); hw_event = 8'h00; wr_en_wdata = 1'b0;
    @(negedge clk);
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    do_read(8'h04, 8'h04, "status_set_wins");
    do_write(8'h04, 8'h04, 1);
    @(negedge clk);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    do_read(8'h04, 8'h00, "status_cleared");

    // GP shadows commit on i2c_active fall
    @(negedge clk); i2c_active = 1'b1;
    do_write(GPB, 8'h11, 2);
    do_write(GPB + 8'd1, 8'h22, 2);
    chk("gp_before_commit", gp_out, 32'h0);
    do_read(GPB, 8'h11, "gp_shadow_read");
    i2c_active = 1'b0;
    @(negedge clk);
    chk("gp_commit", gp_out, 32'h0000_2211);

    // strobe on the commit clk is included
    @(negedge clk); i2c_active = 1'b1;
    @(negedge clk);
    addr = GPB + 8'd2; wdata = 8'h33; wr_en_wdata = 1'b1; i2c_active = 1'b0;
    @(negedge clk); wr_en_wdata = 1'b0;
    chk("gp_commit_same_clk", gp_out, 32'h0033_2211);

    // error counter saturation
    for (int i = 0; i < 150; i++) do_write(8'h00, 8'(i), 1);
    for (int i = 0; i < 150; i++) do_write(8'h20, 8'(i), 1);
    do_read(8'h07, 8'hFF, "errcnt_saturated");
    do_write(8'h07, 8'h12, 1);
    do_read(8'h07, 8'h00, "errcnt_clear_sat");

    // reset mid-transaction: shadows dropped, nothing committed
    @(negedge clk); i2c_active = 1'b1;
    do_write(GPB + 8'd3, 8'h44, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_gp", gp_out, 32'h0);
    chk("rst_ctrl", {24'h0, ctrl}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; i2c_active = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_commit", gp_out, 32'h0);
    do_read(GPB + 8'd3, 8'h00, "rst_shadow_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
